// File: rtl/fp_normalize_iter.sv
// fp_normalize_iter: iterative post-add normaliser producing {mantissa+GRS, exponent, sign} with zero/ovf/unf flags.
module fp_normalize_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W:0]   man_in,
    input  logic [EXP_W-1:0] exp_in,
    input  logic             sign_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] mantisa_norm,
    output logic [EXP_W-1:0] exp_norm,
    output logic             sign_norm,
    output logic             zero_flag,
    output logic             ovf_flag,
    output logic             unf_flag
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
    state_t state, state_n;
    logic [MAN_W:0] m, m_n;
    logic [EXP_W-1:0] e, e_n;
    logic s, s_n, zf, zf_n, of, of_n, uf, uf_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            m <= '0;
            e <= '0;
            s <= 1'b0;
            zf <= 1'b0;
            of <= 1'b0;
            uf <= 1'b0;
        end else begin
            state <= state_n;
            m <= m_n;
            e <= e_n;
            s <= s_n;
            zf <= zf_n;
            of <= of_n;
            uf <= uf_n;
        end
    end

    always_comb begin
        state_n = state;
        m_n = m;
        e_n = e;
        s_n = s;
        zf_n = zf;
        of_n = of;
        uf_n = uf;
        case (state)
            IDLE: if (in_valid) begin
                state_n = NORM;
                m_n = man_in;
                e_n = exp_in;
                s_n = sign_in;
                zf_n = 1'b0;
                of_n = 1'b0;
                uf_n = 1'b0;
            end
            NORM: begin
                state_n = DONE;
                if (m[MAN_W]) begin
                    // right shift folds the dropped bit into sticky
                    m_n = {1'b0, m[MAN_W:2], m[1] | m[0]};
                    e_n = e + EXP_W'(1);
                    if (&e_n) begin
                        m_n = '0;
                        of_n = 1'b1;
                    end
                end else if (m == '0) begin
                    e_n = '0;
                    zf_n = 1'b1;
                end else if (!m[MAN_W-1]) begin
                    if (e < EXP_W'(2)) begin
                        e_n = '0;
                        uf_n = 1'b1;
                    end else begin
                        m_n = m << 1;
                        e_n = e - EXP_W'(1);
                        state_n = NORM;
                    end
                end
            end
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign mantisa_norm = m[MAN_W-1:0];
    assign exp_norm = e;
    assign sign_norm = s;
    assign zero_flag = zf;
    assign ovf_flag = of;
    assign unf_flag = uf;
endmodule

// File: tb/tb_fp_normalize_iter.sv
// tb_fp_normalize_iter: directed spec cases plus randomized operands checked against a leading-zero based model.
module tb_fp_normalize_iter;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready, sign_in = 1'b0, out_valid, out_ready = 1'b0;
    logic [27:0] man_in = '0;
    logic [7:0] exp_in = '0, exp_norm;
    logic [26:0] mantisa_norm;
    logic sign_norm, zero_flag, ovf_flag, unf_flag;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    fp_normalize_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .man_in(man_in), .exp_in(exp_in), .sign_in(sign_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .mantisa_norm(mantisa_norm), .exp_norm(exp_norm), .sign_norm(sign_norm),
        .zero_flag(zero_flag), .ovf_flag(ovf_flag), .unf_flag(unf_flag)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: count leading zeros, limit shifts by exponent headroom.
    task automatic model(input logic [27:0] mi, input int ei, output logic [26:0] mo,
                         output int eo, output logic [2:0] zou, output int lat);
        int lz, sh;
        zou = 3'b000;
        lat = 2;
        if (mi[27]) begin
            if (ei + 1 >= 255) begin
                mo = '0;
                eo = 255;
                zou = 3'b010;
            end else begin
                mo = 27'((mi >> 1) | {27'd0, mi[0]});
                eo = ei + 1;
            end
        end else if (mi == 0) begin
            mo = '0;
            eo = 0;
            zou = 3'b100;
        end else begin
            lz = 0;
            while (!mi[26 - lz]) lz++;
            if (ei >= 1 && lz <= ei - 1) begin
                mo = 27'(mi << lz);
                eo = ei - lz;
                lat = 2 + lz;
            end else begin
                sh = ei > 1 ? ei - 1 : 0;
                mo = 27'(mi << sh);
                eo = 0;
                zou = 3'b001;
                lat = 2 + sh;
            end
        end
    endtask

    task automatic run_op(input logic [27:0] mi, input logic [7:0] ei, input logic si, input int hold);
        logic [26:0] mo;
        int eo, lat, n;
        logic [2:0] zou;
        model(mi, int'(ei), mo, eo, zou, lat);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        man_in = mi;
        exp_in = ei;
        sign_in = si;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            chk("in_ready_busy", in_ready, 0);
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, lat);
        chk("mant", mantisa_norm, mo);
        chk("exp", exp_norm, eo[7:0]);
        chk("sign", sign_norm, si);
        chk("flags", {zero_flag, ovf_flag, unf_flag}, zou);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            man_in = 28'h0800000;
            exp_in = 8'd50;
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_data", {mantisa_norm, exp_norm, zero_flag, ovf_flag, unf_flag}, {mo, eo[7:0], zou});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
    endtask

    initial begin
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_data", {mantisa_norm, exp_norm, sign_norm, zero_flag, ovf_flag, unf_flag}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(28'h8000003, 8'd127, 1'b0, 0);
        run_op(28'h0800005, 8'd100, 1'b0, 0);
        run_op(28'h4000000, 8'd100, 1'b0, 0);
        run_op(28'h0000000, 8'd90, 1'b1, 0);
        run_op(28'h0100000, 8'd3, 1'b0, 0);
        run_op(28'h8000000, 8'd254, 1'b0, 0);
        run_op(28'h0000001, 8'd1, 1'b1, 0);
        run_op(28'h0000001, 8'd200, 1'b0, 0);
        run_op(28'h0800005, 8'd100, 1'b1, 6);
        // async reset while normalising
        in_valid = 1'b1;
        man_in = 28'h0800005;
        exp_in = 8'd100;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_data", {mantisa_norm, exp_norm, sign_norm, zero_flag, ovf_flag, unf_flag}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(28'h0800005, 8'd100, 1'b0, 0);
        for (int k = 0; k < 80; k++) begin
            int pos;
            logic [27:0] mi;
            pos = $urandom_range(0, 28);
            mi = pos == 28 ? 28'd0 : (28'd1 << pos) | (28'($urandom) & ((28'd1 << pos) - 28'd1));
            run_op(mi, 8'($urandom_range(0, 254)), 1'($urandom), k % 9 == 0 ? 2 : 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
